// File: rtl/vdot_seq.sv
// Command sequencer feeding a lane multiply-add unit: issues ADD/SUB/DOT element streams and returns results.
// Optional sticky overflow reporting is enabled by defining VDOT_SEQ_OVF_EN.
module vdot_seq #(
    parameter int unsigned vdw_p       = 32,
    parameter int unsigned len_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cmd_v_i,
    input  logic [1:0]             cmd_op_i,
    input  logic [len_width_p-1:0] cmd_len_i,
    output logic                   cmd_ready_o,
    input  logic                   elem_v_i,
    input  logic [vdw_p-1:0]       elem_a_i,
    input  logic [vdw_p-1:0]       elem_b_i,
    output logic                   elem_ready_o,
    output logic [vdw_p-1:0]       ma_a_o,
    output logic [vdw_p-1:0]       ma_b_o,
    output logic                   ma_op_o,
    output logic                   ma_use_fma_o,
    output logic                   ma_fma_first_o,
    input  logic [vdw_p-1:0]       ma_data_i,
    output logic                   res_v_o,
    output logic [vdw_p-1:0]       res_data_o,
    input  logic                   res_ready_i
`ifdef VDOT_SEQ_OVF_EN
    ,
    input  logic                   ma_ovf_i,
    output logic                   res_ovf_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_ZERO   = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_DOT  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    logic [1:0]             state, state_n;
    logic [1:0]             op_q, op_n;
    logic [len_width_p-1:0] count, count_n;
    logic                   first, first_n;
    logic                   out_v, out_v_n;

    logic accept;
    logic fire;
    logic handshake;
    logic last;

    assign cmd_ready_o  = (state == ST_IDLE);
    assign elem_ready_o = (state == ST_STREAM) && (!out_v || res_ready_i);
    assign accept       = cmd_v_i && cmd_ready_o;
    assign fire         = elem_v_i && elem_ready_o;
    assign handshake    = out_v && res_ready_i;
    assign last         = (count == len_width_p'(1));
    assign res_v_o      = out_v;
    assign res_data_o   = ma_data_i;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            op_q  <= OP_ADD;
            count <= '0;
            first <= 1'b0;
            out_v <= 1'b0;
        end else begin
            state <= state_n;
            op_q  <= op_n;
            count <= count_n;
            first <= first_n;
            out_v <= out_v_n;
        end
    end

    // Next state and multadd drive; the HOLD drive (acc + 0*0) is the default every cycle
    always_comb begin
        state_n        = state;
        op_n           = op_q;
        count_n        = count;
        first_n        = first;
        out_v_n        = out_v;
        ma_a_o         = '0;
        ma_b_o         = '0;
        ma_op_o        = 1'b0;
        ma_use_fma_o   = 1'b1;
        ma_fma_first_o = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_n    = cmd_op_i;
                    count_n = cmd_len_i;
                    first_n = 1'b1;
                    if (cmd_len_i != '0) begin
                        state_n = ST_STREAM;
                    end else if (cmd_op_i == OP_DOT) begin
                        state_n = ST_ZERO;
                    end
                end
            end

            ST_STREAM: begin
                if (handshake) begin
                    out_v_n = 1'b0;
                end
                if (fire) begin
                    count_n = count - len_width_p'(1);
                    first_n = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            ma_use_fma_o = 1'b0;
                            ma_op_o      = (op_q == OP_SUB);
                            ma_a_o       = elem_a_i;
                            ma_b_o       = elem_b_i;
                            out_v_n      = 1'b1;
                        end
                        OP_DOT: begin
                            ma_a_o         = elem_a_i;
                            ma_b_o         = elem_b_i;
                            ma_fma_first_o = first;
                            if (last) begin
                                out_v_n = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    // Reserved ops produce no result, so there is nothing to drain
                    if (last) begin
                        state_n = (op_q == OP_RSVD) ? ST_IDLE : ST_DRAIN;
                    end
                end
            end

            ST_ZERO: begin
                ma_fma_first_o = 1'b1;
                out_v_n        = 1'b1;
                state_n        = ST_DRAIN;
            end

            ST_DRAIN: begin
                if (handshake) begin
                    out_v_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
                out_v_n = 1'b0;
            end
        endcase
    end

`ifdef VDOT_SEQ_OVF_EN
    logic ovf_q, ovf_n;

    // Sticky overflow: DOT keeps it across the whole reduction, ADD/SUB report it per result
    always_comb begin
        ovf_n = ovf_q;
        if (handshake && ((op_q == OP_ADD) || (op_q == OP_SUB))) begin
            ovf_n = 1'b0;
        end
        if (fire && (op_q != OP_RSVD)) begin
            ovf_n = ovf_n | ma_ovf_i;
        end
        if (accept) begin
            ovf_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_n;
        end
    end

    assign res_ovf_o = ovf_q;
`endif

endmodule
